regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file with an integrated busy-bit scoreboard for the 16-bit datapath. It provides two combinational read ports with write-to-read bypass, one synchronous write port, and a hardwired zero register. Per-register busy tracking lets the issue stage detect RAW hazards on in-flight destinations. It sits between decode (read and issue) and writeback (write and busy clear).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_read_port.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, index/data types and constants for the register file with scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int NREG       = 2 ** DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // Index of the hardwired zero register.
    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, issue port.
interface regfile_scoreboard_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rs_busy;
    logic              rt_busy;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W:0]   busy_cnt;

    // Pipeline side: drives indices, writeback and issue; observes data and hazards.
    modport master (
        output rs, rt, we, wa, wd, issue_valid, issue_rd,
        input  rd1, rd2, rs_busy, rt_busy, busy_cnt
    );

    // Register file side.
    modport slave (
        input  rs, rt, we, wa, wd, issue_valid, issue_rd,
        output rd1, rd2, rs_busy, rt_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup with write bypass, zero-register and reset masking.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  bit ZERO_REG = 1'b1,
    localparam int NUM_REG  = 2 ** ADDR_W
) (
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               idx,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               wa,
    input  logic [DATA_W-1:0]               wd,
    input  logic [NUM_REG-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REG-1:0]              busy_vec,
    output logic [DATA_W-1:0]               data,
    output logic                            busy
);

    logic is_zero;
    logic wr_hit;

    assign is_zero = ZERO_REG && (idx == ADDR_W'(ZERO_IDX));
    assign wr_hit  = we && (wa == idx);

    // Select array or bypassed write data; a completing write hides the hazard it resolves.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        data = regs[idx];
        busy = busy_vec[idx];
        if (wr_hit) begin
            data = wd;
            busy = 1'b0;
        end
        // Zero register and reset override everything, including the bypass.
        if (is_zero || reset) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass, hardwired zero register and busy-bit scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  bit ZERO_REG = 1'b1,
    localparam int NUM_REG  = 2 ** ADDR_W
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);

    logic [NUM_REG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REG-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]                busy_cnt_q, busy_cnt_d;
    logic                           wr_en;
    logic                           iss_en;

    // Writes and issues aimed at the zero register are dropped entirely.
    assign wr_en  = bus.we && !(ZERO_REG && (bus.wa == ADDR_W'(ZERO_IDX)));
    assign iss_en = bus.issue_valid && !(ZERO_REG && (bus.issue_rd == ADDR_W'(ZERO_IDX)));

    // Next register array: a single write port.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wa] = bus.wd;
        end
    end

    // Next busy vector: writeback clears, issue sets; the set is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[bus.wa] = 1'b0;
        end
        if (iss_en) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
    end

    // Population count of the next busy vector, registered so busy_cnt tracks busy_q.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // State registers; reset discards any write or issue on a coincident edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data array is reset too, because reads after reset must return zero.
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_rs (
        .reset    (reset),
        .idx      (bus.rs),
        .we       (bus.we),
        .wa       (bus.wa),
        .wd       (bus.wd),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .data     (bus.rd1),
        .busy     (bus.rs_busy)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_rt (
        .reset    (reset),
        .idx      (bus.rt),
        .we       (bus.we),
        .wa       (bus.wa),
        .wd       (bus.wd),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .data     (bus.rd2),
        .busy     (bus.rt_busy)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: vector table, hand-written reset/scoreboard sequences, random vs model.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;
    localparam int N  = NREG;

    logic clk = 1'b0;
    logic reset;

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: architectural register contents and pending-writer flags.
    reg_data_t m_regs [N];
    bit        m_busy [N];

    typedef struct {
        int we; int wa; int wd; int iv; int ird; int rs; int rt;
        int e_rd1; int e_rd2; int e_rsb; int e_rtb; int e_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    // Architectural read value seen by decode this cycle.
    function automatic reg_data_t model_rd(input int idx);
        if (idx == 0) return '0;
        if (bus.we && int'(bus.wa) == idx) return bus.wd;
        return m_regs[idx];
    endfunction

    // Hazard: pending writer that is not completing this very cycle.
    function automatic bit model_busy(input int idx);
        if (idx == 0) return 1'b0;
        return m_busy[idx] && !(bus.we && int'(bus.wa) == idx);
    endfunction

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        bus.we          = we;
        bus.wa          = wa;
        bus.wd          = wd;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.rs          = rs;
        bus.rt          = rt;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rd1"},     32'(bus.rd1),     32'(model_rd(int'(bus.rs))));
        check({tag, ".rd2"},     32'(bus.rd2),     32'(model_rd(int'(bus.rt))));
        check({tag, ".rs_busy"}, 32'(bus.rs_busy), 32'(model_busy(int'(bus.rs))));
        check({tag, ".rt_busy"}, 32'(bus.rt_busy), 32'(model_busy(int'(bus.rt))));
    endtask

    // Advance one edge, update the model from the inputs held at that edge, check busy_cnt.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset) begin
            if (bus.we && bus.wa != '0) begin
                m_regs[bus.wa] = bus.wd;
                m_busy[bus.wa] = 1'b0;
            end
            if (bus.issue_valid && bus.issue_rd != '0) begin
                m_busy[bus.issue_rd] = 1'b1;
            end
        end
        #1;
        check({tag, ".busy_cnt"}, 32'(bus.busy_cnt), 32'(model_cnt()));
    endtask

    initial begin
        // Directed vectors from a clean reset state: bypass, zero register, scoreboard, collision.
        tbl[0] = '{1, 5, 'hBEEF, 0, 0, 5, 5, 'hBEEF, 'hBEEF, 0, 0, 0};
        tbl[1] = '{0, 0, 0,      0, 0, 5, 0, 'hBEEF, 0,      0, 0, 0};
        tbl[2] = '{1, 0, 'hFFFF, 1, 0, 0, 5, 0,      'hBEEF, 0, 0, 0};
        tbl[3] = '{0, 0, 0,      1, 2, 2, 5, 0,      'hBEEF, 0, 0, 1};
        tbl[4] = '{0, 0, 0,      0, 0, 2, 2, 0,      0,      1, 1, 1};
        tbl[5] = '{1, 2, 'h0042, 0, 0, 2, 3, 'h0042, 0,      0, 0, 0};
        tbl[6] = '{0, 0, 0,      1, 4, 4, 2, 0,      'h0042, 0, 0, 1};
        tbl[7] = '{1, 4, 'h0007, 1, 4, 4, 7, 'h0007, 0,      0, 0, 1};
        tbl[8] = '{0, 0, 0,      0, 0, 4, 5, 'h0007, 'hBEEF, 1, 0, 1};
        tbl[9] = '{1, 7, 'h1111, 1, 7, 7, 4, 'h1111, 'h0007, 0, 1, 2};

        model_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, 3'd3, 3'd5);
        #2;
        check("reset.rd1",      32'(bus.rd1),      32'h0);
        check("reset.rs_busy",  32'(bus.rs_busy),  32'h0);
        check("reset.busy_cnt", 32'(bus.busy_cnt), 32'h0);
        #10;
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            drive(1'(tbl[i].we), AW'(tbl[i].wa), DW'(tbl[i].wd), 1'(tbl[i].iv),
                  AW'(tbl[i].ird), AW'(tbl[i].rs), AW'(tbl[i].rt));
            #2;
            check($sformatf("vec%0d.rd1", i),     32'(bus.rd1),     32'(tbl[i].e_rd1));
            check($sformatf("vec%0d.rd2", i),     32'(bus.rd2),     32'(tbl[i].e_rd2));
            check($sformatf("vec%0d.rs_busy", i), 32'(bus.rs_busy), 32'(tbl[i].e_rsb));
            check($sformatf("vec%0d.rt_busy", i), 32'(bus.rt_busy), 32'(tbl[i].e_rtb));
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.cnt_tbl", i), 32'(bus.busy_cnt), 32'(tbl[i].e_cnt));
        end

        // Asynchronous reset mid-cycle, with a write and an issue in flight.
        drive(1'b1, 3'd3, 16'h1234, 1'b0, '0, 3'd3, 3'd0);
        tick("r3wr");
        drive(1'b0, '0, '0, 1'b1, 3'd6, 3'd3, 3'd6);
        tick("iss6");
        drive(1'b0, '0, '0, 1'b0, '0, 3'd3, 3'd6);
        #2;
        check("pre_rst.rd1",     32'(bus.rd1),     32'h1234);
        check("pre_rst.rt_busy", 32'(bus.rt_busy), 32'h1);
        reset = 1'b1;
        drive(1'b1, 3'd3, 16'h5555, 1'b1, 3'd5, 3'd3, 3'd6);
        #1;
        check("in_rst.rd1",      32'(bus.rd1),      32'h0);
        check("in_rst.rt_busy",  32'(bus.rt_busy),  32'h0);
        check("in_rst.busy_cnt", 32'(bus.busy_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("rst_edge.rd1",      32'(bus.rd1),      32'h0);
        check("rst_edge.busy_cnt", 32'(bus.busy_cnt), 32'h0);
        drive(1'b0, '0, '0, 1'b0, '0, 3'd3, 3'd5);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("post_rst.rd1",      32'(bus.rd1),      32'h0);
        check("post_rst.rd2",      32'(bus.rd2),      32'h0);
        check("post_rst.busy_cnt", 32'(bus.busy_cnt), 32'h0);
        tick("post_rst");

        // Fill the scoreboard R1..R7: busy_cnt must step 1..7 without wrapping.
        for (int k = 1; k < N; k++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(k), AW'(k), 3'd0);
            #2;
            check($sformatf("fill%0d.rs_busy", k), 32'(bus.rs_busy), 32'h0);
            tick($sformatf("fill%0d", k));
            check($sformatf("fill%0d.cnt", k), 32'(bus.busy_cnt), 32'(k));
        end
        drive(1'b0, '0, '0, 1'b0, '0, 3'd7, 3'd1);
        #2;
        check("full.rs_busy", 32'(bus.rs_busy), 32'h1);
        reset = 1'b1;
        #1;
        check("full_rst.busy_cnt", 32'(bus.busy_cnt), 32'h0);
        check("full_rst.rs_busy",  32'(bus.rs_busy),  32'h0);
        #1;
        reset = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)), DW'($urandom),
                  1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, N - 1)),
                  AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
            #2;
            check_model($sformatf("rnd%0d", i));
            tick($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
